// File: rtl/pixel_readout_buffer.sv
// Captures the four per-phase pixel samples from the shared DATA bus and queues them,
// tagged with index and frame-last, in a first-word-fall-through FIFO drained by valid/ready.
module pixel_readout_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read1,
    input  logic              read2,
    input  logic              read3,
    input  logic              read4,
    input  logic [7:0]        data_in,
    output logic [7:0]        out_data,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clr_err,
    output logic              overflow,
    output logic              seq_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StExp1, StExp2, StExp3, StExp4} state_e;

    state_e state_q, state_d;

    logic [3:0] rd, rd_q, fall;
    logic       multi_hi, multi_fall, one_hi;
    logic [7:0] sample_q;
    logic [1:0] fall_idx, exp_idx;
    logic       push, seq_set;
    logic [1:0] push_idx;

    logic [10:0]       mem [DEPTH];
    logic [10:0]       head;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              empty, full, pop, wr_en, drop;
    logic              overflow_q, overflow_d, seq_err_q, seq_err_d;
    logic [FCNT_W-1:0] frame_cnt_q;

    assign rd         = {read4, read3, read2, read1};
    assign fall       = rd_q & ~rd;
    // x & (x-1) is non-zero exactly when more than one bit is set
    assign multi_hi   = |(rd & (rd - 4'd1));
    assign multi_fall = |(fall & (fall - 4'd1));
    assign one_hi     = |rd & ~multi_hi;
    assign exp_idx    = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q     <= 4'b0;
            sample_q <= 8'h00;
            state_q  <= StExp1;
        end else begin
            rd_q    <= rd;
            state_q <= state_d;
            if (one_hi) begin
                sample_q <= data_in;
            end
        end
    end

    always_comb begin
        fall_idx = 2'd0;
        unique case (fall)
            4'b0001: fall_idx = 2'd0;
            4'b0010: fall_idx = 2'd1;
            4'b0100: fall_idx = 2'd2;
            4'b1000: fall_idx = 2'd3;
            default: fall_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_idx = 2'd0;
        seq_set  = multi_hi;
        if (multi_fall) begin
            seq_set = 1'b1;
            state_d = StExp1;
        end else if (|fall) begin
            if (fall_idx == exp_idx) begin
                push     = 1'b1;
                push_idx = fall_idx;
                unique case (state_q)
                    StExp1:  state_d = StExp2;
                    StExp2:  state_d = StExp3;
                    StExp3:  state_d = StExp4;
                    default: state_d = StExp1;
                endcase
            end else if (fall_idx == 2'd0) begin
                // An unexpected READ1 is taken as the start of a fresh frame
                seq_set  = 1'b1;
                push     = 1'b1;
                push_idx = 2'd0;
                state_d  = StExp2;
            end else begin
                seq_set = 1'b1;
                state_d = StExp1;
            end
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = ~empty & out_ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        seq_err_d  = seq_err_q;
        if (clr_err) begin
            overflow_d = 1'b0;
            seq_err_d  = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (seq_set) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {sample_q, push_idx, push_idx == 2'd3};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_en && push_idx == 2'd3) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign head      = mem[rd_ptr_q];
    assign out_valid = ~empty;
    assign out_data  = out_valid ? head[10:3] : 8'h00;
    assign out_idx   = out_valid ? head[2:1] : 2'd0;
    assign out_last  = out_valid & head[0];
    assign overflow  = overflow_q;
    assign seq_err   = seq_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
